mux_sel_arb4: RTL and testbench



---
 rtl/mux_sel_arb4.sv | 111 +++++++++++
 tb/tb_mux_sel_arb4.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_arb4.sv
// Round-robin arbiter feeding the select of a quad 4-1 mux and capturing its output
// behind a valid/ready handshake. Define MUX_ARB_FASTPATH_EN to re-arbitrate on acceptance.
module mux_sel_arb4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  output logic [3:0]       gnt,
  output logic [1:0]       S,
  input  logic [WIDTH-1:0] mux_out,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         s_q, s_d;
  logic [1:0]         last_q, last_d;
  logic [3:0]         gnt_q, gnt_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   data_q, data_d;

  // Lowest offset from last+1 wins; scanning offsets high-to-low lets the last write win.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] sel);
    onehot = 4'b0001 << sel;
  endfunction

`ifdef MUX_ARB_FASTPATH_EN
  logic [3:0] req_masked;
  assign req_masked = req & ~gnt_q;
`endif

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    last_d  = last_q;
    gnt_d   = 4'b0000;
    valid_d = valid_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          s_d     = rr_pick(req, last_q);
          last_d  = rr_pick(req, last_q);
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        data_d  = mux_out;
        valid_d = 1'b1;
        gnt_d   = onehot(s_q);
        state_d = HOLD;
      end
      HOLD: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
`ifdef MUX_ARB_FASTPATH_EN
          // The lane granted this cycle is masked so its still-high req is not re-served.
          if (|req_masked) begin
            s_d     = rr_pick(req_masked, last_q);
            last_d  = rr_pick(req_masked, last_q);
            state_d = CAPTURE;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= 2'd0;
      last_q  <= 2'd3;
      gnt_q   <= 4'b0000;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign S         = s_q;
  assign gnt       = gnt_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_mux_sel_arb4.sv
// Bench for mux_sel_arb4: directed scenarios plus randomized traffic against a transaction model.
module tb_mux_sel_arb4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] S;
  logic [3:0] mux_out;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef MUX_ARB_FASTPATH_EN
  localparam int SPACING = 2;
`else
  localparam int SPACING = 3;
`endif

  // Quad 4-1 mux with InA..InD = 1, 2, 3, 4.
  assign mux_out = 4'(S) + 4'd1;

  always #5 clk = ~clk;

  mux_sel_arb4 #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .S(S),
    .mux_out(mux_out), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  // Transaction-level reference: a pending selection, a held result, and the grant pulse.
  logic [1:0] m_s, m_last;
  logic [3:0] m_gnt, m_data;
  logic       m_valid, m_pend;

  task automatic step();
    logic [3:0] ng, pool;
    logic       arb, acc;
    @(posedge clk);
    if (rst) begin
      m_s = 0; m_last = 3; m_gnt = 0; m_valid = 0; m_data = 0; m_pend = 0;
    end else begin
      ng = 0; pool = 0; arb = 0;
      acc = m_valid && out_ready;
      if (m_pend) begin
        m_data = 4'(m_s) + 4'd1; m_valid = 1; ng = 4'b0001 << m_s; m_pend = 0;
      end else if (!m_valid) begin
        arb = 1; pool = req;
      end else if (acc) begin
        m_valid = 0;
`ifdef MUX_ARB_FASTPATH_EN
        arb = 1; pool = req & ~m_gnt;
`endif
      end
      if (arb) begin
        for (int k = 1; k <= 4; k++) begin
          int ln;
          ln = (int'(m_last) + k) % 4;
          if (pool[ln]) begin
            m_s = 2'(ln); m_last = 2'(ln); m_pend = 1;
            break;
          end
        end
      end
      m_gnt = ng;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; step(); step(); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; req = 4'b1111; out_ready = 1;
    for (int c = 0; c < 2; c++) begin
      step();
      n_cmp++;
      if ({S, gnt, out_valid, out_data} !== 11'd0) begin
        n_fail++;
        $display("FAIL reset cyc%0d: S=%0d gnt=%b valid=%b data=%0d, want all 0", c, S, gnt, out_valid, out_data);
      end
    end
    rst = 0; req = 0;
  endtask

  task automatic test_single_lane();
    do_reset();
    req = 4'b0100; out_ready = 1;
    step();
    n_cmp++;
    if (S !== 2'd2 || gnt !== 4'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_sel: S=%0d gnt=%b valid=%b, want S=2 gnt=0000 valid=0", S, gnt, out_valid);
    end
    step();
    n_cmp++;
    if (out_data !== 4'd3 || out_valid !== 1'b1 || gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_cap: data=%0d valid=%b gnt=%b, want 3 1 0100", out_data, out_valid, gnt);
    end
    req = 0;
    step();
    n_cmp++;
    if (gnt !== 4'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after: gnt=%b valid=%b, want 0000 0", gnt, out_valid);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] g_seen[5];
    logic [3:0] d_seen[5];
    int         cyc_seen[5];
    int         n = 0;
    logic [3:0] exp_g[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req = 4'b1111; out_ready = 1;
    for (int c = 0; c < 40 && n < 5; c++) begin
      step();
      if (gnt !== 4'b0) begin
        g_seen[n] = gnt; d_seen[n] = out_data; cyc_seen[n] = c; n++;
      end
    end
    n_cmp++;
    if (n != 5) begin
      n_fail++;
      $display("FAIL fair_count: saw %0d grants, want 5", n);
    end
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (g_seen[i] !== exp_g[i] || d_seen[i] !== 4'(i % 4 + 1)) begin
        n_fail++;
        $display("FAIL fair_%0d: gnt=%b data=%0d, want %b %0d", i, g_seen[i], d_seen[i], exp_g[i], i % 4 + 1);
      end
      if (i > 0) begin
        n_cmp++;
        if (cyc_seen[i] - cyc_seen[i-1] != SPACING) begin
          n_fail++;
          $display("FAIL fair_spacing_%0d: %0d cycles, want %0d", i, cyc_seen[i] - cyc_seen[i-1], SPACING);
        end
      end
    end
    req = 0;
  endtask

  task automatic test_back_to_back_backpressure();
    bit got = 0;
    do_reset();
    req = 4'b0010; out_ready = 0;
    step(); step();
    n_cmp++;
    if (gnt !== 4'b0010 || out_data !== 4'd2 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_capture: gnt=%b data=%0d valid=%b, want 0010 2 1", gnt, out_data, out_valid);
    end
    req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 4'd2 || gnt !== 4'b0 || S !== 2'd1) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: valid=%b data=%0d gnt=%b S=%0d, want 1 2 0000 1", c, out_valid, out_data, gnt, S);
      end
    end
    out_ready = 1;
    for (int c = 0; c < 8 && !got; c++) begin
      step();
      if (gnt !== 4'b0) got = 1;
    end
    n_cmp++;
    if (!got || gnt !== 4'b0100 || out_data !== 4'd3) begin
      n_fail++;
      $display("FAIL bp_next: got=%0d gnt=%b data=%0d, want 0100 3", got, gnt, out_data);
    end
    req = 0;
  endtask

  task automatic test_reset_mid();
    bit got = 0;
    do_reset();
    req = 4'b1000; out_ready = 0;
    step(); step();
    req = 0;
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 4'd4) begin
      n_fail++;
      $display("FAIL rmid_hold: valid=%b data=%0d, want 1 4", out_valid, out_data);
    end
    rst = 1;
    step();
    n_cmp++;
    if ({S, gnt, out_valid, out_data} !== 11'd0) begin
      n_fail++;
      $display("FAIL rmid_reset: S=%0d gnt=%b valid=%b data=%0d, want all 0", S, gnt, out_valid, out_data);
    end
    rst = 0; req = 4'b1111; out_ready = 1;
    for (int c = 0; c < 8 && !got; c++) begin
      step();
      if (gnt !== 4'b0) got = 1;
    end
    n_cmp++;
    if (!got || gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL rmid_first: got=%0d gnt=%b, want 0001", got, gnt);
    end
    req = 0;
  endtask

  task automatic test_fastpath_mask();
    bit got = 0;
    do_reset();
    req = 4'b0001; out_ready = 1;
    step(); step();
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL mask_gnt: gnt=%b, want 0001", gnt);
    end
    step();
    req = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++;
      if (gnt !== 4'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mask_idle_%0d: gnt=%b valid=%b, want 0000 0", c, gnt, out_valid);
      end
    end
    req = 4'b0001;
    for (int c = 0; c < 6 && !got; c++) begin
      step();
      if (gnt !== 4'b0) got = 1;
    end
    n_cmp++;
    if (!got || gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL mask_regrant: got=%0d gnt=%b, want 0001", got, gnt);
    end
    req = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req       = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 49) == 0);
      step();
      n_cmp++;
      if ({S, gnt, out_valid, out_data} !== {m_s, m_gnt, m_valid, m_data}) begin
        n_fail++;
        $display("FAIL random_%0d: S=%0d gnt=%b valid=%b data=%0d, want S=%0d gnt=%b valid=%b data=%0d",
                 c, S, gnt, out_valid, out_data, m_s, m_gnt, m_valid, m_data);
      end
    end
    rst = 0; req = 0;
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_fairness();
    test_back_to_back_backpressure();
    test_reset_mid();
    test_fastpath_mask();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
